// File: rtl/rs_pkg.sv
// Shared reservation-station types: the entry layout, the "value present" tag,
// and the op payload field slices shared with the opcode definitions.
package rs_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned OP_W  = 17;

  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  // Op payload is {fun7, fun3, opcode}
  localparam int unsigned OPC_LSB  = 0;
  localparam int unsigned OPC_W    = 7;
  localparam int unsigned FUN3_LSB = 7;
  localparam int unsigned FUN3_W   = 3;
  localparam int unsigned FUN7_LSB = 10;
  localparam int unsigned FUN7_W   = 7;

  typedef struct packed {
    logic [TAG_W-1:0] q;
    logic [XLEN-1:0]  v;
  } rs_opnd_t;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] tag;
    rs_opnd_t         j;
    rs_opnd_t         k;
    logic [XLEN-1:0]  imm;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker: older[i][j] set means entry j is older than entry i.
// Grants the ready entry that has no older ready entry.
module rs_age_select #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0][N-1:0] older,
  input  logic [N-1:0]        ready,
  output logic [N-1:0]        grant_c
);

  always_comb begin
    grant_c = '0;
    for (int i = 0; i < N; i++) begin
      grant_c[i] = ready[i] && ((older[i] & ready & ~(N'(1) << i)) == '0);
    end
  end

endmodule

// File: rtl/rs_station.sv
// Age-ordered reservation station with CDB wakeup and flush.
// Define RS_PERF_EN to build the full-cycle and issue performance counters.
module rs_station
  import rs_pkg::*;
#(
  parameter int unsigned RS_DEPTH = 8,
  parameter int unsigned CDB_N    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [OP_W-1:0]          disp_op,
  input  logic [TAG_W-1:0]         disp_tag,
  input  logic [TAG_W-1:0]         disp_qj,
  input  logic [TAG_W-1:0]         disp_qk,
  input  logic [XLEN-1:0]          disp_vj,
  input  logic [XLEN-1:0]          disp_vk,
  input  logic [XLEN-1:0]          disp_imm,
  input  logic [CDB_N-1:0]         cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]   cdb_tag,
  input  logic [CDB_N*XLEN-1:0]    cdb_data,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [OP_W-1:0]          iss_op,
  output logic [TAG_W-1:0]         iss_tag,
  output logic [XLEN-1:0]          iss_vj,
  output logic [XLEN-1:0]          iss_vk,
  output logic [XLEN-1:0]          iss_imm,
  output logic [$clog2(RS_DEPTH):0] count,
  output logic [31:0]              perf_full_cycles,
  output logic [31:0]              perf_issued
);

  localparam int unsigned CNT_W = $clog2(RS_DEPTH) + 1;
  localparam int unsigned IDX_W = $clog2(RS_DEPTH);

  rs_entry_t                         ent_q [RS_DEPTH];
  rs_entry_t                         ent_d [RS_DEPTH];
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_q, older_d;
  logic [CNT_W-1:0]                  count_q, count_d;
  logic [RS_DEPTH-1:0]               valid_vec, rdy, grant;
  logic [IDX_W-1:0]                  free_idx;
  logic                              disp_fire, iss_fire;

  // Lowest bus index wins when several buses carry the same tag
  function automatic rs_opnd_t snoop(input rs_opnd_t o);
    rs_opnd_t r;
    r = o;
    for (int b = int'(CDB_N) - 1; b >= 0; b--) begin
      if (o.q != TAG_NONE && cdb_valid[b] && o.q == cdb_tag[b*TAG_W +: TAG_W]) begin
        r.q = TAG_NONE;
        r.v = cdb_data[b*XLEN +: XLEN];
      end
    end
    return r;
  endfunction

  always_comb begin
    valid_vec = '0;
    rdy       = '0;
    free_idx  = '0;
    for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
      valid_vec[i] = ent_q[i].valid;
      rdy[i]       = ent_q[i].valid && ent_q[i].j.q == TAG_NONE && ent_q[i].k.q == TAG_NONE;
      if (!ent_q[i].valid) free_idx = IDX_W'(i);
    end
  end

  rs_age_select #(.N(RS_DEPTH)) u_age_select (
    .older   (older_q),
    .ready   (rdy),
    .grant_c (grant)
  );

  assign disp_ready = count_q < CNT_W'(RS_DEPTH);
  assign iss_valid  = |rdy;
  assign disp_fire  = disp_valid && disp_ready;
  assign iss_fire   = iss_valid && iss_ready;
  assign count      = count_q;

  // Issue payload comes only from registered state via the one-hot grant
  always_comb begin
    iss_op  = '0;
    iss_tag = '0;
    iss_vj  = '0;
    iss_vk  = '0;
    iss_imm = '0;
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      if (grant[i]) begin
        iss_op  |= ent_q[i].op;
        iss_tag |= ent_q[i].tag;
        iss_vj  |= ent_q[i].j.v;
        iss_vk  |= ent_q[i].k.v;
        iss_imm |= ent_q[i].imm;
      end
    end
  end

  always_comb begin
    ent_d   = ent_q;
    older_d = older_q;
    count_d = count_q + CNT_W'(disp_fire) - CNT_W'(iss_fire);
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      if (ent_q[i].valid) begin
        ent_d[i].j = snoop(ent_q[i].j);
        ent_d[i].k = snoop(ent_q[i].k);
      end
      if (grant[i] && iss_ready) ent_d[i].valid = 1'b0;
    end
    // New entry is youngest: nobody counts it as older, it counts every live entry
    if (disp_fire) begin
      ent_d[free_idx].valid = 1'b1;
      ent_d[free_idx].op    = disp_op;
      ent_d[free_idx].tag   = disp_tag;
      ent_d[free_idx].j     = snoop('{q: disp_qj, v: disp_vj});
      ent_d[free_idx].k     = snoop('{q: disp_qk, v: disp_vk});
      ent_d[free_idx].imm   = disp_imm;
      for (int k = 0; k < int'(RS_DEPTH); k++) older_d[k][free_idx] = 1'b0;
      older_d[free_idx] = valid_vec & ~(RS_DEPTH'(1) << free_idx);
    end
    if (flush) begin
      for (int i = 0; i < int'(RS_DEPTH); i++) ent_d[i].valid = 1'b0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RS_DEPTH); i++) ent_q[i] <= '0;
      older_q <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      older_q <= older_d;
      count_q <= count_d;
    end
  end

`ifdef RS_PERF_EN
  logic [31:0] perf_full_q, perf_iss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_full_q <= '0;
      perf_iss_q  <= '0;
    end else begin
      if (count_q == CNT_W'(RS_DEPTH)) perf_full_q <= perf_full_q + 32'd1;
      if (iss_fire)                    perf_iss_q  <= perf_iss_q + 32'd1;
    end
  end

  assign perf_full_cycles = perf_full_q;
  assign perf_issued      = perf_iss_q;
`else
  assign perf_full_cycles = '0;
  assign perf_issued      = '0;
`endif

endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station: expected issues are queued as stimulus is
// driven and a negedge monitor pops and compares each accepted issue.
module tb_rs_station;

  logic        clk = 1'b0;
  logic        rst_n, flush, disp_valid, disp_ready, iss_valid, iss_ready;
  logic [16:0] disp_op, iss_op;
  logic [4:0]  disp_tag, disp_qj, disp_qk, iss_tag;
  logic [31:0] disp_vj, disp_vk, disp_imm, iss_vj, iss_vk, iss_imm;
  logic [1:0]  cdb_valid;
  logic [9:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic [3:0]  count;
  logic [31:0] perf_full_cycles, perf_issued;

  typedef struct {
    logic [4:0]  tag;
    logic [16:0] op;
    logic [31:0] vj, vk, imm;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  rs_station dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_tag(disp_tag), .disp_qj(disp_qj), .disp_qk(disp_qk),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_imm(disp_imm),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_tag(iss_tag), .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_imm(iss_imm),
    .count(count), .perf_full_cycles(perf_full_cycles), .perf_issued(perf_issued)
  );

  function automatic logic [16:0] op_of(input logic [4:0] t);
    return {2'b00, t, 3'b000, 7'h33};
  endfunction

  function automatic logic [31:0] imm_of(input logic [4:0] t);
    return 32'h1000 + 32'(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_iss(input logic [4:0] t, input logic [31:0] vj, input logic [31:0] vk);
    exp_t e;
    e.tag = t; e.op = op_of(t); e.vj = vj; e.vk = vk; e.imm = imm_of(t);
    sb.push_back(e);
  endtask

  task automatic dispatch(input logic [4:0] t, input logic [4:0] qj, input logic [31:0] vj,
                          input logic [4:0] qk, input logic [31:0] vk);
    disp_valid = 1'b1; disp_tag = t; disp_op = op_of(t); disp_imm = imm_of(t);
    disp_qj = qj; disp_vj = vj; disp_qk = qk; disp_vk = vk;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic set_cdb(input logic [1:0] v, input logic [4:0] t1, input logic [31:0] d1,
                         input logic [4:0] t0, input logic [31:0] d0);
    cdb_valid = v; cdb_tag = {t1, t0}; cdb_data = {d1, d0};
  endtask

  // Scoreboard monitor: every accepted issue must match the next expectation
  always @(negedge clk) begin
    if (rst_n && iss_valid && iss_ready) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_issue: got tag %0d expected no issue", iss_tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (iss_tag !== e.tag || iss_op !== e.op || iss_vj !== e.vj ||
            iss_vk !== e.vk || iss_imm !== e.imm)
          $display("FAIL issue_payload: got tag %0d op %0h vj %0h vk %0h imm %0h expected tag %0d op %0h vj %0h vk %0h imm %0h",
                   iss_tag, iss_op, iss_vj, iss_vk, iss_imm, e.tag, e.op, e.vj, e.vk, e.imm);
        else passed++;
      end
    end
  end

  initial begin
    logic [31:0] exp_full, exp_iss;
`ifdef RS_PERF_EN
    exp_full = 32'd5; exp_iss = 32'd5;
`else
    exp_full = 32'd0; exp_iss = 32'd0;
`endif
    rst_n = 1'b0; flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0;
    disp_op = '0; disp_tag = '0; disp_qj = '0; disp_qk = '0;
    disp_vj = '0; disp_vk = '0; disp_imm = '0;
    set_cdb(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_disp_ready", 32'(disp_ready), 32'd1);
    chk("reset_iss_valid", 32'(iss_valid), 32'd0);
    chk("reset_iss_tag", 32'(iss_tag), 32'd0);
    chk("reset_perf_issued", perf_issued, 32'd0);

    // Three ready entries issue in dispatch order
    @(posedge clk); #1;
    iss_ready = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      expect_iss(5'(t), 32'(t) * 32'h10, 32'h20 + 32'(t));
      dispatch(5'(t), 5'd0, 32'(t) * 32'h10, 5'd0, 32'h20 + 32'(t));
    end
    repeat (2) tick();
    @(negedge clk);
    chk("drain_count", 32'(count), 32'd0);

    // Wakeup on CDB bus 1
    dispatch(5'd4, 5'd7, 32'hDEAD, 5'd0, 32'h22);
    @(negedge clk);
    chk("wait_iss_valid", 32'(iss_valid), 32'd0);
    set_cdb(2'b10, 5'd7, 32'h55, 5'd0, 32'd0);
    expect_iss(5'd4, 32'h55, 32'h22);
    tick();
    set_cdb(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    @(negedge clk);
    chk("wake_iss_valid", 32'(iss_valid), 32'd1);
    chk("wake_iss_vj", iss_vj, 32'h55);
    tick();

    // Dispatch-cycle snoop on CDB bus 0
    set_cdb(2'b01, 5'd0, 32'd0, 5'd9, 32'hABCD);
    expect_iss(5'd5, 32'h3, 32'hABCD);
    dispatch(5'd5, 5'd0, 32'h3, 5'd9, 32'h0);
    set_cdb(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    @(negedge clk);
    chk("snoop_iss_vk", iss_vk, 32'hABCD);
    tick();

    // Fill with unready entries and hold full for five cycles
    for (int t = 10; t < 18; t++) dispatch(5'(t), 5'd20, 32'd0, 5'd0, 32'd0);
    @(negedge clk);
    chk("full_disp_ready", 32'(disp_ready), 32'd0);
    chk("full_count", 32'(count), 32'd8);
    repeat (5) tick();
    @(negedge clk);
    chk("perf_full_cycles", perf_full_cycles, exp_full);
    chk("perf_issued", perf_issued, exp_iss);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_full_count", 32'(count), 32'd0);
    chk("flush_disp_ready", 32'(disp_ready), 32'd1);

    // Younger ready entry bypasses older waiting entry
    expect_iss(5'd22, 32'h222, 32'h0);
    dispatch(5'd21, 5'd6, 32'd0, 5'd0, 32'h211);
    dispatch(5'd22, 5'd0, 32'h222, 5'd0, 32'h0);
    tick();
    set_cdb(2'b01, 5'd0, 32'd0, 5'd6, 32'h66);
    expect_iss(5'd21, 32'h66, 32'h211);
    tick();
    set_cdb(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    @(negedge clk);
    chk("older_wake_tag", 32'(iss_tag), 32'd21);
    tick();

    // Stalled offer is pre-empted by an older entry that wakes up
    iss_ready = 1'b0;
    dispatch(5'd23, 5'd6, 32'd0, 5'd0, 32'h233);
    dispatch(5'd24, 5'd0, 32'h244, 5'd0, 32'h0);
    @(negedge clk);
    chk("stall_offer_tag", 32'(iss_tag), 32'd24);
    set_cdb(2'b01, 5'd0, 32'd0, 5'd6, 32'h77);
    tick();
    set_cdb(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    @(negedge clk);
    chk("preempt_tag", 32'(iss_tag), 32'd23);
    chk("preempt_vj", iss_vj, 32'h77);
    expect_iss(5'd23, 32'h77, 32'h233);
    expect_iss(5'd24, 32'h244, 32'h0);
    @(posedge clk); #1;
    iss_ready = 1'b1;
    repeat (3) tick();

    // Flush with a simultaneous dispatch on a half-full station
    iss_ready = 1'b0;
    for (int t = 1; t <= 4; t++) dispatch(5'(t), 5'd0, 32'(t), 5'd0, 32'd0);
    @(negedge clk);
    chk("half_count", 32'(count), 32'd4);
    chk("half_iss_valid", 32'(iss_valid), 32'd1);
    flush = 1'b1;
    dispatch(5'd9, 5'd0, 32'h9, 5'd0, 32'd0);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_iss_valid", 32'(iss_valid), 32'd0);
    @(posedge clk); #1;
    iss_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rs_station.md
# rs_station

Parametrised reservation station for the out-of-order RISC-V core. It sits between the decode/rename stage and one functional unit (ALU, branch or address generation). It holds up to RS_DEPTH renamed instructions and snoops CDB_N result buses to wake up pending operands. It issues the oldest entry whose operands are all ready through a valid/ready handshake. This generalises the single-bank station to configurable depth, widths, CDB count and strict age-ordered issue, and adds flush.

## Interface
- XLEN, 32, operand/result width
- RS_DEPTH, 8, number of entries (2..32)
- TAG_W, 5, producer tag width; tag 0 means "value present"
- OP_W, 17, opaque op payload ({fun7, fun3, opcode})
- CDB_N, 2, number of common data buses snooped

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  discard all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  entry available
- disp_op  in  OP_W  op payload
- disp_tag  in  TAG_W  destination tag of this instruction
- disp_qj, disp_qk  in  TAG_W  source producer tags (0 = value valid)
- disp_vj, disp_vk  in  XLEN  source values, used when the matching q is 0
- disp_imm  in  XLEN  immediate
- cdb_valid  in  CDB_N  broadcast valid per bus
- cdb_tag  in  CDB_N*TAG_W  broadcast tags, bus 0 in the LSBs
- cdb_data  in  CDB_N*XLEN  broadcast results
- iss_valid  out  1  ready entry offered
- iss_ready  in  1  FU accepts
- iss_op, iss_tag  out  OP_W, TAG_W  payload of the offered entry
- iss_vj, iss_vk, iss_imm  out  XLEN  operands
- count  out  clog2(RS_DEPTH)+1  occupied entries
- perf_full_cycles, perf_issued  out  32  performance counters

## Operation
- Each entry holds: valid, op, tag, qj, vj, qk, vk, imm. An entry is ready when valid and qj == 0 and qk == 0.
- Dispatch: on disp_valid && disp_ready, write into the lowest-index free entry. Mark it youngest in the age matrix: row i is set to all other valid entries' "younger-than" bits.
- Dispatch snoop: if a disp_q tag equals a valid cdb_tag in the same cycle, store that cdb_data and set q to 0. The value is never lost.
- Wakeup: for every valid entry and every bus, if q != 0 && cdb_valid[b] && q == cdb_tag[b], then v <= cdb_data[b] and q <= 0. Equal tags on two buses are illegal; the lowest bus index wins.
- Issue select: iss_valid = any ready entry. The payload is from the oldest ready entry according to the age matrix. On iss_valid && iss_ready that entry is freed at the edge.
- Outputs are combinational from registered state only. There is no path from disp_* or cdb_* to the iss_* outputs.
- disp_ready = (count < RS_DEPTH), computed from registers. A freeing issue does not open the slot in the same cycle.
- flush: at the next edge all valid bits are cleared and count becomes 0. flush dominates dispatch, wakeup and issue in the same cycle. The perf counters are not cleared.
- count updates as +1 on dispatch, -1 on issue; both together leave it unchanged.

## Timing
- Reset values: all entries invalid, count = 0, disp_ready = 1, iss_valid = 0, iss_* payload = 0, perf counters = 0. Reset asserted mid-operation drops all entries immediately.
- Dispatch at edge t with operands present: iss_valid is asserted during cycle t+1 at the earliest.
- CDB broadcast in cycle t: the woken entry may issue in cycle t+1.
- The handshake holds while iss_valid && !iss_ready. The offered entry stays selected unless an older entry becomes ready, in which case the older entry pre-empts it. The FU samples only on acceptance.
- Full: disp_ready = 0 until an issue or flush edge. Empty: iss_valid = 0.

## Configuration
- RS_PERF_EN defined: perf_full_cycles increments on every cycle with count == RS_DEPTH. perf_issued increments on every issue handshake. Both counters wrap at 2^32.
- RS_PERF_EN undefined: both ports are driven constant 0 and no counter flops are built.

## Structure
- Shared package rs_pkg holds:
  - the entry struct,
  - the TAG_NONE = 0 constant,
  - the op field slices (opcode[6:0], fun3, fun7), shared with the opcode definitions.
- One sub-module, rs_age_select: takes the age matrix and the ready vector, and returns a one-hot grant for the oldest ready entry. It is purely combinational and tested standalone.

## Test plan
- Dispatch 3 entries with qj = qk = 0 (tags 1, 2, 3), iss_ready = 1 -> tags issued 1, 2, 3 on consecutive cycles; count ends at 0.
- Dispatch tag 4 with qj = 7, then CDB bus 1 sends tag 7 = 0x55 -> iss_valid rises the next cycle with iss_vj = 0x55.
- Dispatch with qk = 9 while cdb bus 0 carries tag 9 = 0xABCD in the same cycle -> the entry becomes ready, and iss_vk = 0xABCD.
- Fill all 8 entries with unready operands -> disp_ready = 0. Hold for 5 cycles: perf_full_cycles = 5 with RS_PERF_EN, 0 without.
- Dispatch older A (waits on tag 6) and younger B (ready). B issues first. Broadcast tag 6 -> A issues next cycle.
- Assert flush together with disp_valid on a half-full station -> count = 0, iss_valid = 0 next cycle, and the dispatched entry is discarded.
